// File: rtl/bp_update_scheduler.sv
// Sequences fetch lookups and buffered resolve updates onto a
// single-write-port tournament branch predictor; owns the speculative GHR.
module bp_update_scheduler #(
  parameter int HISTORY_LEN  = 8,
  parameter int QUEUE_DEPTH  = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   lookup_valid,
  input  logic [15:0]            lookup_pc,
  output logic                   lookup_stall,
  output logic                   lookup_prediction,
  output logic [HISTORY_LEN-1:0] lookup_history,
  input  logic                   resolve_valid,
  input  logic [15:0]            resolve_pc,
  input  logic [HISTORY_LEN-1:0] resolve_history,
  input  logic                   resolve_outcome,
  input  logic                   resolve_mispredict,
  output logic                   resolve_ready,
  output logic [15:0]            pc_bits_read,
  input  logic                   pred_prediction,
  output logic                   write_enabled,
  output logic [15:0]            pc_bits_write,
  output logic [HISTORY_LEN-1:0] history_write,
  output logic                   outcome,
  output logic [HISTORY_LEN-1:0] history_read
);

  localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam int SW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
  localparam logic [CW-1:0] DEPTH = CW'(QUEUE_DEPTH);
  localparam logic [SW-1:0] SMAX  = SW'(STARVE_LIMIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    DEFER,
    FORCE
  } state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          count_q, count_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [SW-1:0]          starve_q, starve_d;
  logic [HISTORY_LEN-1:0] ghr_q, ghr_d;

  logic [15:0]            pc_mem   [QUEUE_DEPTH];
  logic [HISTORY_LEN-1:0] hist_mem [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0] out_mem;

  logic enq;
  logic issue;
  logic accept;
  logic blocked;

  assign resolve_ready = (count_q < DEPTH);
  assign lookup_stall  = (state_q == FORCE);
  assign accept        = lookup_valid & ~lookup_stall;
  assign enq           = resolve_valid & resolve_ready;
  assign issue         = (count_q != '0) &
                         (~lookup_valid | (state_q == FORCE));
  assign blocked       = (state_q == DEFER) & lookup_valid;

  assign lookup_prediction = pred_prediction;
  assign lookup_history    = ghr_q;
  assign history_read      = ghr_q;
  assign pc_bits_read      = lookup_pc;

  assign write_enabled = issue;
  assign pc_bits_write = pc_mem[rd_ptr_q];
  assign history_write = hist_mem[rd_ptr_q];
  assign outcome       = out_mem[rd_ptr_q];

  // Storage needs no reset: the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (enq) begin
      pc_mem[wr_ptr_q]   <= resolve_pc;
      hist_mem[wr_ptr_q] <= resolve_history;
      out_mem[wr_ptr_q]  <= resolve_outcome;
    end
  end

  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (enq) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (issue) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (enq & ~issue) begin
      count_d = count_q + CW'(1);
    end else if (~enq & issue) begin
      count_d = count_q - CW'(1);
    end
  end

  // Mispredict recovery overrides the speculative shift.
  always_comb begin
    ghr_d = ghr_q;
    if (resolve_valid & resolve_mispredict) begin
      ghr_d = {resolve_history[HISTORY_LEN-2:0], resolve_outcome};
    end else if (accept) begin
      ghr_d = {ghr_q[HISTORY_LEN-2:0], pred_prediction};
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (issue | (state_q == IDLE)) begin
      starve_d = '0;
    end else if (blocked & (starve_q != SMAX)) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (count_d != '0) state_d = DEFER;
      end
      DEFER: begin
        if (count_d == '0) begin
          state_d = IDLE;
        end else if (blocked &
                     ((starve_q == SMAX) | (count_q == DEPTH))) begin
          state_d = FORCE;
        end
      end
      FORCE: begin
        state_d = (count_d == '0) ? IDLE : DEFER;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      starve_q <= '0;
      ghr_q    <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      starve_q <= starve_d;
      ghr_q    <= ghr_d;
    end
  end

endmodule
